sys_bus_mem_responder: RTL and testbench

Memory-side responder for the 16-bit CPU system bus: it latches the address the CPU's registers drive onto `SysBus`, performs a read or write on a word-addressed on-chip RAM, and returns read data to the datapath's `DataIn` with a `Ready` handshake. It also decodes one memory-mapped I/O word (switches in, LEDs out). It sits between the CPU control/datapath and memory, and is the target end of the bus that the datapath initiates on.

---
 rtl/sys_bus_mem_responder.sv | 75 +++++++
 tb/tb_sys_bus_mem_responder.sv | 108 ++++++++++
 2 files changed

// File: rtl/sys_bus_mem_responder.sv
// sys_bus_mem_responder: bus target that latches an address, accesses word RAM or one I/O word, and pulses Ready
module sys_bus_mem_responder #(
  parameter int ADDR_W = 10,
  parameter int WAIT_STATES = 0,
  parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] SysBus,
  input  logic        AddrLatch,
  input  logic        Read,
  input  logic        Write,
  output logic [15:0] DataOut,
  output logic        Ready,
  output logic        Fault,
  input  logic [15:0] Switches,
  output logic [15:0] Leds
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [15:0] addr, wdata;
  logic [3:0] cnt;
  logic is_write;
  logic [15:0] mem [2**ADDR_W];
  logic io_hit, ram_hit, access;
  logic [ADDR_W-1:0] idx;
  assign io_hit = addr == IO_ADDR;
  assign ram_hit = (addr >> ADDR_W) == 16'd0;
  assign access = state == BUSY && cnt == 4'd0;
  assign idx = addr[ADDR_W-1:0];
  // RAM write port; I/O decode wins over RAM, and contents survive reset
  always_ff @(posedge Clock)
    if (access && is_write && !io_hit && ram_hit) mem[idx] <= wdata;
  // Transaction FSM with registered read data and completion strobes
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      addr <= '0;
      wdata <= '0;
      cnt <= '0;
      is_write <= 1'b0;
      DataOut <= '0;
      Ready <= 1'b0;
      Fault <= 1'b0;
      Leds <= '0;
    end else begin
      Ready <= 1'b0;
      Fault <= 1'b0;
      case (state)
        IDLE: begin
          if (AddrLatch) addr <= SysBus;
          if (Write) begin
            wdata <= SysBus;
            is_write <= 1'b1;
            cnt <= 4'(WAIT_STATES);
            state <= BUSY;
          end else if (Read) begin
            is_write <= 1'b0;
            cnt <= 4'(WAIT_STATES);
            state <= BUSY;
          end
        end
        BUSY:
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else begin
            state <= DONE;
            Ready <= 1'b1;
            Fault <= !io_hit && !ram_hit;
            if (!is_write) DataOut <= io_hit ? Switches : ram_hit ? mem[idx] : 16'h0000;
            else if (io_hit) Leds <= wdata;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sys_bus_mem_responder.sv
// tb_sys_bus_mem_responder: directed checks on a zero-wait and a three-wait instance
module tb_sys_bus_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst0 = 1'b1, rst3 = 1'b1;
  logic [15:0] bus0 = '0, bus3 = '0, sw0 = '0, sw3 = '0;
  logic al0 = 0, rd0 = 0, wr0 = 0, al3 = 0, rd3 = 0, wr3 = 0;
  logic [15:0] dout0, dout3, leds0, leds3;
  logic rdy0, rdy3, flt0, flt3;
  int compared = 0, mismatched = 0;
  int pulses;

  sys_bus_mem_responder #(.ADDR_W(10), .WAIT_STATES(0), .IO_ADDR(16'hFFFF)) d0 (
    .Clock(clk), .Reset(rst0), .SysBus(bus0), .AddrLatch(al0), .Read(rd0), .Write(wr0),
    .DataOut(dout0), .Ready(rdy0), .Fault(flt0), .Switches(sw0), .Leds(leds0));
  sys_bus_mem_responder #(.ADDR_W(10), .WAIT_STATES(3), .IO_ADDR(16'hFFFF)) d3 (
    .Clock(clk), .Reset(rst3), .SysBus(bus3), .AddrLatch(al3), .Read(rd3), .Write(wr3),
    .DataOut(dout3), .Ready(rdy3), .Fault(flt3), .Switches(sw3), .Leds(leds3));

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op0(input string tag, input logic wr, input logic [15:0] a, input logic [15:0] d, input logic exp_fault);
    @(negedge clk); al0 = 1; bus0 = a; rd0 = 0; wr0 = 0;
    @(negedge clk); al0 = 0; bus0 = d; wr0 = wr; rd0 = !wr;
    @(negedge clk); wr0 = 0; rd0 = 0; check({tag, "_busy"}, 16'(rdy0), 16'd0);
    @(negedge clk); check({tag, "_ready"}, 16'(rdy0), 16'd1); check({tag, "_fault"}, 16'(flt0), 16'(exp_fault));
    @(negedge clk); check({tag, "_ready_end"}, 16'(rdy0), 16'd0);
  endtask

  task automatic op3(input string tag, input logic wr, input logic [15:0] a, input logic [15:0] d, input logic hold);
    @(negedge clk); al3 = 1; bus3 = a; rd3 = 0; wr3 = 0;
    @(negedge clk); al3 = 0; bus3 = d; wr3 = wr; rd3 = !wr;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!hold) begin wr3 = 0; rd3 = 0; end
      check({tag, "_wait"}, 16'(rdy3), 16'd0);
    end
    @(negedge clk); check({tag, "_ready"}, 16'(rdy3), 16'd1); wr3 = 0; rd3 = 0;
    @(negedge clk); check({tag, "_ready_end"}, 16'(rdy3), 16'd0);
  endtask

  initial begin
    #2;
    check("rst_dout0", dout0, 16'h0000);
    check("rst_ready0", 16'(rdy0), 16'd0);
    check("rst_fault0", 16'(flt0), 16'd0);
    check("rst_leds0", leds0, 16'h0000);
    check("rst_dout3", dout3, 16'h0000);
    @(negedge clk); rst0 = 0; rst3 = 0;
    // reset aborts a pending write on the wait-state instance
    op3("pre_w5", 1, 16'h0005, 16'h1111, 0);
    @(negedge clk); al3 = 1; bus3 = 16'h0005;
    @(negedge clk); al3 = 0; bus3 = 16'hBEEF; wr3 = 1;
    @(negedge clk); wr3 = 0; check("abort_e0", 16'(rdy3), 16'd0);
    @(negedge clk); check("abort_e1", 16'(rdy3), 16'd0);
    @(negedge clk); check("abort_e2", 16'(rdy3), 16'd0);
    rst3 = 1;
    @(negedge clk); rst3 = 0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); pulses += int'(rdy3); end
    check("abort_no_ready", 16'(pulses), 16'd0);
    op3("rd5", 0, 16'h0005, 16'h0000, 0);
    check("abort_data", dout3, 16'h1111);
    // strobes held through BUSY must not start a second transaction
    op3("hold_rd5", 0, 16'h0005, 16'h0000, 1);
    check("hold_data", dout3, 16'h1111);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); pulses += int'(rdy3); end
    check("hold_no_extra", 16'(pulses), 16'd0);
    // zero-wait instance: RAM write/read
    op0("w10", 1, 16'h0010, 16'h1234, 0);
    check("w10_dout", dout0, 16'h0000);
    op0("r10", 0, 16'h0010, 16'h0000, 0);
    check("r10_dout", dout0, 16'h1234);
    // memory-mapped I/O
    op0("wio", 1, 16'hFFFF, 16'h00FF, 0);
    check("wio_leds", leds0, 16'h00FF);
    sw0 = 16'hA5A5;
    op0("rio", 0, 16'hFFFF, 16'h0000, 0);
    check("rio_dout", dout0, 16'hA5A5);
    check("rio_leds", leds0, 16'h00FF);
    // out-of-range accesses fault and do not alias onto address 0
    op0("w0", 1, 16'h0000, 16'hCAFE, 0);
    op0("woor", 1, 16'h0400, 16'h5555, 1);
    op0("roor", 0, 16'h0400, 16'h0000, 1);
    check("roor_dout", dout0, 16'h0000);
    op0("r0", 0, 16'h0000, 16'h0000, 0);
    check("r0_dout", dout0, 16'hCAFE);
    // simultaneous Read and Write: write wins, one Ready, DataOut held
    @(negedge clk); al0 = 1; bus0 = 16'h0020;
    @(negedge clk); al0 = 0; bus0 = 16'h7777; rd0 = 1; wr0 = 1;
    @(negedge clk); rd0 = 0; wr0 = 0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); pulses += int'(rdy0); end
    check("rw_one_ready", 16'(pulses), 16'd1);
    check("rw_dout_held", dout0, 16'hCAFE);
    op0("r20", 0, 16'h0020, 16'h0000, 0);
    check("r20_dout", dout0, 16'h7777);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
